// File: rtl/axi_slice_dc_token_reader.sv
// Read endpoint of a token-based dual-clock buffer: syncs write tokens, streams slots out in order, returns read tokens.
// Latency: token toggle to valid_o in 3 clk_i edges, or 4 with AXI_DC_READER_SYNC3_EN defined (3-stage sync).
// Backpressure: data_o is held while valid_o && !ready_i; isolate_i forces valid_o low and drains/discards entries.
module axi_slice_dc_token_reader #(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_WIDTH = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               isolate_i,
    input  logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_i,
    input  logic [BUFFER_WIDTH-1:0]            writetoken_i,
    output logic [BUFFER_WIDTH-1:0]            readpointer_o,
    output logic                               valid_o,
    output logic [DATA_WIDTH-1:0]              data_o,
    input  logic                               ready_i
);

`ifdef AXI_DC_READER_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif
    localparam int IDX_W = $clog2(BUFFER_WIDTH);

    logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [BUFFER_WIDTH-1:0] slot_full;
    logic [BUFFER_WIDTH-1:0] rd_onehot;
    logic [IDX_W-1:0]        rd_idx;
    logic [IDX_W-1:0]        rd_idx_nxt;
    logic [DATA_WIDTH-1:0]   head_dat;
    logic                    reg_vld;
    logic                    consume;
    logic                    load;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= writetoken_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Slot payload is only trusted once its synchronized token disagrees with our read token.
    always_comb begin
        slot_full  = sync_q[SYNC_STAGES-1] ^ readpointer_o;
        consume    = reg_vld & (ready_i | isolate_i);
        load       = slot_full[rd_idx] & (~reg_vld | consume);
        rd_idx_nxt = (rd_idx == IDX_W'(BUFFER_WIDTH - 1)) ? '0 : rd_idx + 1'b1;
        rd_onehot  = BUFFER_WIDTH'(1) << rd_idx;
        head_dat   = data_async_i[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_vld       <= 1'b0;
            data_o        <= '0;
            readpointer_o <= '0;
            rd_idx        <= '0;
        end else if (load) begin
            reg_vld       <= 1'b1;
            data_o        <= head_dat;
            readpointer_o <= readpointer_o ^ rd_onehot;
            rd_idx        <= rd_idx_nxt;
        end else if (consume) begin
            reg_vld       <= 1'b0;
        end
    end

    assign valid_o = reg_vld & ~isolate_i;

endmodule

// File: tb/tb_axi_slice_dc_token_reader.sv
// Bench for axi_slice_dc_token_reader: 8-slot and 5-slot instances, directed phases plus a randomized scoreboard phase.
module tb_axi_slice_dc_token_reader;
    localparam int DW  = 16;
    localparam int BW  = 8;
    localparam int BW5 = 5;
`ifdef AXI_DC_READER_SYNC3_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, isolate, ready, valid;
    logic [BW*DW-1:0]  data_async;
    logic [BW-1:0]     wt, rp;
    logic [DW-1:0]     dout;

    logic              iso5, ready5, valid5;
    logic [BW5*DW-1:0] data5;
    logic [BW5-1:0]    wt5, rp5;
    logic [DW-1:0]     dout5;
    assign iso5 = 1'b0;

    axi_slice_dc_token_reader #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW)) u_dut (
        .clk_i(clk), .rst_i(rst), .isolate_i(isolate), .data_async_i(data_async),
        .writetoken_i(wt), .readpointer_o(rp), .valid_o(valid), .data_o(dout), .ready_i(ready));

    axi_slice_dc_token_reader #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW5)) u_dut5 (
        .clk_i(clk), .rst_i(rst), .isolate_i(iso5), .data_async_i(data5),
        .writetoken_i(wt5), .readpointer_o(rp5), .valid_o(valid5), .data_o(dout5), .ready_i(ready5));

    int            vectors = 0;
    int            errors  = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp5_q[$];
    bit            mon_en = 1'b0, mon5_en = 1'b0, run5 = 1'b0, done5 = 1'b0;
    int            widx = 0, widx5 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Writer side of the 8-slot link: data and token go into the next slot in ring order.
    task automatic put8(input logic [DW-1:0] v);
        data_async[widx*DW +: DW] = v;
        wt[widx] = ~wt[widx];
        widx = (widx + 1) % BW;
    endtask

    task automatic wait_valid(input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            ok = valid;
        end
        if (!ok) fail_now(name);
    endtask

    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_d;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (prev_hold) begin
                check("hold_valid", valid, 1);
                check("hold_data", dout, prev_d);
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_beat");
                else check("stream_data", dout, exp_q.pop_front());
            end
            prev_hold = valid && !ready;
            prev_d    = dout;
        end else begin
            prev_hold = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon5_en && !rst && valid5 && ready5) begin
            if (exp5_q.size() == 0) fail_now("unexpected_beat5");
            else check("stream_data5", dout5, exp5_q.pop_front());
        end
    end

    // Writer for the non-power-of-two instance.
    initial begin
        logic [DW-1:0] v;
        ready5 = 1'b0;
        wait (run5);
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #2;
            ready5 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0 && wt5[widx5] == rp5[widx5]) begin
                v = DW'($urandom);
                exp5_q.push_back(v);
                data5[widx5*DW +: DW] = v;
                wt5[widx5] = ~wt5[widx5];
                widx5 = (widx5 + 1) % BW5;
            end
        end
        ready5 = 1'b1;
        for (int i = 0; i < 60 && exp5_q.size() > 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty5", exp5_q.size(), 0);
        check("rp_returned5", rp5, wt5);
        done5 = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] rp_pre, rp_hold;
        logic [DW-1:0] d_hold, v;
        rst = 1'b1; isolate = 1'b0; ready = 1'b0;
        data_async = '0; wt = '0; data5 = '0; wt5 = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid, 0);
        check("rst_rp", rp, 0);
        check("rst_data", dout, 0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Eight full slots drain back-to-back, one per cycle.
        @(posedge clk); #2;
        for (int k = 1; k <= 8; k++) put8(DW'(k));
        ready = 1'b1;
        wait_valid(10, "stream_timeout");
        for (int k = 1; k <= 8; k++) begin
            check("burst_valid", valid, 1);
            check("burst_data", dout, k);
            @(posedge clk); #1;
        end
        check("burst_empty", valid, 0);
        check("burst_rp", rp, 8'hFF);

        // Isolate with four pending entries: hidden, drained, tokens returned.
        @(posedge clk); #2;
        ready  = 1'b0;
        rp_pre = rp;
        for (int k = 0; k < 4; k++) put8(DW'(16'h100 + k));
        wait_valid(10, "iso_fill_timeout");
        repeat (LAT + 1) @(posedge clk);
        #2;
        isolate = 1'b1;
        #1;
        check("iso_valid", valid, 0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("iso_valid", valid, 0);
        end
        check("iso_rp", rp ^ rp_pre, 8'h0F);
        check("iso_rp_wt", rp, wt);
        #1;
        isolate = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("post_iso_valid", valid, 0);
        end

        // Back-pressure: head held for five cycles, then randomized traffic.
        mon_en = 1'b1;
        run5   = 1'b1;
        @(posedge clk); #2;
        v = DW'($urandom);
        exp_q.push_back(v);
        put8(v);
        wait_valid(10, "bp_timeout");
        rp_hold = rp;
        d_hold  = dout;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid", valid, 1);
            check("bp_data", dout, d_hold);
            check("bp_rp", rp, rp_hold);
        end
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #2;
            ready = (c % 50 < 40) ? ($urandom_range(0, 3) != 0) : 1'b0;
            if ($urandom_range(0, 2) != 0 && wt[widx] == rp[widx]) begin
                v = DW'($urandom);
                exp_q.push_back(v);
                put8(v);
            end
        end
        ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
        check("rp_returned", rp, wt);
        for (int i = 0; i < 400 && !done5; i++) @(posedge clk);
        if (!done5) fail_now("bw5_timeout");
        mon_en  = 1'b0;
        mon5_en = 1'b0;

        // Asynchronous reset in the middle of a held entry.
        @(posedge clk); #2;
        ready = 1'b0;
        put8(16'h55);
        put8(16'h66);
        wait_valid(10, "midrst_fill_timeout");
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("midrst_valid", valid, 0);
        check("midrst_rp", rp, 0);
        check("midrst_data", dout, 0);
        wt = '0; widx = 0; data_async = '0;
        wt5 = '0; widx5 = 0;
        exp_q.delete();
        exp5_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // First post-reset load: slot 0, fixed edge count from token toggle.
        @(posedge clk); #2;
        put8(16'hA5);
        for (int e = 1; e <= LAT; e++) begin
            @(posedge clk); #1;
            if (e < LAT) begin
                check("lat_early_valid", valid, 0);
            end else begin
                check("lat_valid", valid, 1);
                check("lat_data", dout, 16'hA5);
                check("lat_rp", rp, 8'h01);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial mon5_en = 1'b1;

endmodule
